// File: rtl/tanh_ctrl_pkg.sv
// Shared definitions for the tanh-unit control sequencer: state encoding,
// step-counter width and the default terminal step.
package tanh_ctrl_pkg;

    localparam int unsigned COUNT_W = 13;

    // 256 weight groups x 16 steps, followed by a 16-step final phase
    localparam logic [COUNT_W-1:0] LAST_COUNT = 13'h100F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control/status bundle between the run requester and the sequencer; enable
// and count also feed the signal decoder.
interface ctrl_sequencer_if #(
    parameter int unsigned COUNT_W = tanh_ctrl_pkg::COUNT_W
);
    logic               start;
    logic               stall;
    logic               abort;
    logic               enable;
    logic [COUNT_W-1:0] count;
    logic               done;
    logic               aborted;

    modport master (
        output start, stall, abort,
        input  enable, count, done, aborted
    );

    modport slave (
        input  start, stall, abort,
        output enable, count, done, aborted
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Step sequencer for one tanh-unit run: counts 0..LAST_COUNT while enabled,
// then pulses done; abort cancels a run and pulses aborted instead.
module ctrl_sequencer #(
    parameter int unsigned              COUNT_W    = tanh_ctrl_pkg::COUNT_W,
    parameter logic [COUNT_W-1:0]       LAST_COUNT = tanh_ctrl_pkg::LAST_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_sequencer_if.slave   bus
);
    import tanh_ctrl_pkg::*;

    state_e             state_q,   state_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic               enable_q,  enable_d;
    logic               done_q,    done_d;
    logic               aborted_q, aborted_d;

    // Outputs are computed one cycle ahead so every port comes straight off a flop.
    always_comb begin
        state_d   = state_q;
        count_d   = '0;
        enable_d  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = RUN;
                    enable_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = ABORT;
                    aborted_d = 1'b1;
                end else if (bus.stall) begin
                    count_d  = count_q;
                    enable_d = 1'b1;
                end else if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    count_d  = count_q + COUNT_W'(1);
                    enable_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            enable_q  <= enable_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.enable  = enable_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: behavioural run model compared every cycle, plus
// directed scenarios with hand-computed latencies and counts.
module tb_ctrl_sequencer;
    localparam int LAST = 'h100F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ctrl_sequencer_if #(.COUNT_W(13)) bus ();

    ctrl_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a run is either active with a step number, or is
    // reporting its outcome for one cycle, or the block is idle.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    bit m_abt  = 1'b0;
    int m_cnt  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_done = 1'b0; m_abt = 1'b0; m_cnt = 0;
        end else if (m_run) begin
            if (bus.abort) begin
                m_run = 1'b0; m_abt = 1'b1; m_cnt = 0;
            end else if (!bus.stall) begin
                if (m_cnt == LAST) begin
                    m_run = 1'b0; m_done = 1'b1; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end else if (m_done || m_abt) begin
            m_done = 1'b0; m_abt = 1'b0;
        end else if (bus.start && !bus.abort) begin
            m_run = 1'b1; m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.enable !== m_run || bus.count !== 13'(m_cnt) ||
            bus.done !== m_done || bus.aborted !== m_abt) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t dut en=%b cnt=%h done=%b abt=%b model en=%b cnt=%h done=%b abt=%b",
                     $time, bus.enable, bus.count, bus.done, bus.aborted,
                     m_run, 13'(m_cnt), m_done, m_abt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cnt(input int v, input int lim);
        int k = 0;
        while (!(bus.enable && bus.count == 13'(v)) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) chk("wait_cnt_timeout", k, 0);
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!bus.done && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) chk("wait_done_timeout", k, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    // Start a run and observe it to completion, optionally stalling at one count.
    task automatic measure(input int stall_at, input int stall_len,
                           output int lat, output int en_cyc,
                           output int last_cnt, output int at_cnt);
        int k  = 1;
        int st = 0;
        lat = -1; en_cyc = 0; last_cnt = -1; at_cnt = 0;
        pulse_start();
        while (k < 6000) begin
            if (bus.enable) begin
                en_cyc++;
                last_cnt = int'(bus.count);
                if (int'(bus.count) == stall_at) at_cnt++;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (stall_at >= 0 && bus.enable && int'(bus.count) == stall_at && st < stall_len) begin
                bus.stall = 1'b1;
                st++;
            end else begin
                bus.stall = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.stall = 1'b0;
    endtask

    initial begin
        int lat, en_cyc, last_cnt, at_cnt;
        bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_enable", bus.enable, 0);
        chk("reset_count", bus.count, 0);
        chk("reset_pulses", {bus.done, bus.aborted}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full unstalled run at the default terminal count
        measure(-1, 0, lat, en_cyc, last_cnt, at_cnt);
        chk("full_latency", lat, 4113);
        chk("full_enable_cycles", en_cyc, 4112);
        chk("full_last_count", last_cnt, 'h100F);
        @(negedge clk);
        chk("after_done_idle", bus.enable, 0);

        // Five stall cycles at count 7 push done out by five
        measure(7, 5, lat, en_cyc, last_cnt, at_cnt);
        chk("stall_latency", lat, 4118);
        chk("stall_enable_cycles", en_cyc, 4117);
        chk("stall_hold_count7", at_cnt, 6);
        @(negedge clk);

        // Abort with stall at count 12
        pulse_start();
        wait_cnt(12, 50);
        bus.stall = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_pulse", bus.aborted, 1);
        chk("abort_enable", bus.enable, 0);
        chk("abort_count", bus.count, 0);
        chk("abort_no_done", bus.done, 0);
        bus.stall = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_then_idle", {bus.enable, bus.aborted, bus.done}, 0);

        // start re-pulsed mid-run and in the DONE cycle is ignored
        pulse_start();
        wait_cnt(3, 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_ignored_count", bus.count, 4);
        wait_done(5000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_start_not_queued", {bus.enable, bus.count}, 0);
        @(negedge clk);
        chk("still_idle", bus.enable, 0);
        pulse_start();
        chk("new_start_enable", bus.enable, 1);
        chk("new_start_count", bus.count, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);

        // start together with abort in IDLE does nothing
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_idle", {bus.enable, bus.done, bus.aborted}, 0);

        // Asynchronous reset mid-run, then start on the first edge after release
        pulse_start();
        wait_cnt('h805, 2200);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_enable", bus.enable, 0);
        @(negedge clk);
        chk("async_rst_no_pulse", {bus.done, bus.aborted}, 0);
        rst = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_rst_start", {bus.enable, bus.count}, {1'b1, 13'h0});
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.start = ($urandom % 8) == 0;
            bus.stall = ($urandom % 4) == 0;
            bus.abort = ($urandom % 100) == 0;
            rst       = ($urandom % 700) == 0;
        end
        bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
